clock_ctrl: RTL
===============

Name: clock_ctrl

Overview:
Timekeeping and time-set controller for the digital clock. It consumes the 1 Hz tick and the 500 ms blink level from the clock divisor and maintains 24-hour hh:mm:ss. A three-state mode FSM driven by debounced buttons lets the user set hours and minutes. It drives binary time fields and digit-blank enables to the display encoder downstream.

Parameters:
HOURS_MOD, 24, hour wrap modulus; valid values 24 or 12; for 12 the range is 0..11
TIMEOUT_S, 30, seconds of button inactivity in a set state before auto-return to RUN

Ports:
clk  in  1  system clock, 100 MHz
rst_i  in  1  asynchronous active-low reset
tick_1hz  in  1  one-cycle pulse, once per second
blink  in  1  level, toggles every 500 ms
btn_mode  in  1  one-cycle pulse, debounced upstream
btn_inc  in  1  one-cycle pulse, debounced upstream
btn_dec  in  1  one-cycle pulse, debounced upstream
hours  out  5  current hours, binary
minutes  out  6  current minutes, binary
seconds  out  6  current seconds, binary
blank_hours  out  1  1 = hours digits off
blank_minutes  out  1  1 = minutes digits off
setting  out  1  1 = FSM in a set state
day_pulse  out  1  one-cycle pulse on wrap from last hour:59:59 to 00:00:00

Behaviour:
- Reset: asynchronous on rst_i low. All outputs 0; state ST_RUN; timeout counter 0. All outputs are registered.
- ST_RUN:
  - On tick_1hz, seconds increments and wraps at 59 to 0. The wrap carries into minutes, which wraps the same way and carries into hours, which wraps at HOURS_MOD-1.
  - The new value is visible one cycle after the tick.
  - day_pulse asserts in the same cycle the fields show 00:00:00.
- Transitions on btn_mode: ST_RUN -> ST_SET_HOUR -> ST_SET_MIN -> ST_RUN.
- Leaving ST_SET_MIN, by button or timeout: seconds cleared to 0 in that cycle.
- In ST_SET_HOUR and ST_SET_MIN:
  - tick_1hz does not advance time.
  - btn_inc / btn_dec adjust only the selected field, modulo its range (hours HOURS_MOD, minutes 60). No carry into other fields. day_pulse is never asserted by edits.
- Same-cycle priority:
  - btn_mode beats btn_inc/btn_dec; the edit is ignored.
  - btn_inc together with btn_dec gives no change.
  - tick_1hz with btn_mode in ST_RUN: the tick is applied, then the state advances. The set state starts from the incremented time.
- Timeout:
  - The counter clears on entry to a set state and on any button pulse.
  - It increments on tick_1hz while in a set state.
  - When it reaches TIMEOUT_S, the FSM returns to ST_RUN with seconds cleared.
  - Counter width is $clog2(TIMEOUT_S+1).
- Blanking:
  - blank_hours = (state == ST_SET_HOUR) && !blink, registered.
  - blank_minutes = (state == ST_SET_MIN) && !blink, registered.
  - Both are 0 in ST_RUN.
- setting = 1 in either set state.
- Reset mid-edit: returns immediately to 00:00:00 in ST_RUN; the partial edit is discarded.

Decomposition:
- Package clock_pkg:
  - typedef enum logic [1:0] ctrl_state_t {ST_RUN, ST_SET_HOUR, ST_SET_MIN}
  - localparams SEC_MOD = 60 and MIN_MOD = 60
  - field widths HOUR_W = 5, MIN_W = 6, SEC_W = 6
- Sub-module mod_counter:
  - parameters MOD and W
  - inputs: inc, dec, clr
  - outputs: value, and a wrap pulse on the up-wrap only
  - instantiated three times; the FSM and carry gating stay in clock_ctrl.

Test Plan:
- Reset then 59 ticks in ST_RUN -> seconds = 59 with minutes and hours still 0. The 60th tick gives 00:01:00 one cycle later.
- Preload 23:59:59 via set mode, then tick -> 00:00:00, day_pulse high exactly one cycle. With HOURS_MOD = 12, preload 11:59:59 -> 00:00:00.
- btn_mode, then btn_dec at hours 0 -> hours = 23. btn_mode, then btn_inc at minutes 59 -> minutes = 0 with hours unchanged. btn_mode -> ST_RUN, seconds = 0.
- In ST_SET_HOUR with blink toggling -> blank_hours follows !blink, blank_minutes = 0. Ticks give no time change. After 30 ticks with no buttons -> ST_RUN and setting = 0.
- Same-cycle events:
  - btn_inc with btn_dec -> no change.
  - btn_mode with btn_inc -> state advances, field unchanged.
  - tick with btn_mode in ST_RUN -> seconds +1 and ST_SET_HOUR.
- Assert rst_i low asynchronously, mid-cycle, while in ST_SET_MIN at 12:34 -> all outputs 0 immediately, state ST_RUN.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// clock_pkg : shared state encoding and field widths for the clock controller
// Rev 1.0
// ============================================================================
package clock_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } ctrl_state_t;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
// mod_counter : modulo up/down counter with synchronous clear and up-wrap pulse
// Rev 1.0
// ============================================================================
module mod_counter #(
  parameter int MOD = 60,
  parameter int W   = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  logic up;
  logic down;

  // Simultaneous inc and dec cancel out.
  assign up   = inc && !dec;
  assign down = dec && !inc;
  assign wrap = up && !clr && (value == TOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (up) begin
      value <= (value == TOP) ? '0 : value + 1'b1;
    end else if (down) begin
      value <= (value == '0) ? TOP : value - 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/clock_ctrl.sv
`default_nettype none
// ============================================================================
// clock_ctrl : 24/12-hour timekeeping with button-driven hour/minute setting
// Rev 1.0
// ============================================================================
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int HOURS_MOD = 24,
  parameter int TIMEOUT_S = 30
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              tick_1hz,
  input  logic              blink,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic              btn_dec,
  output logic [HOUR_W-1:0] hours,
  output logic [MIN_W-1:0]  minutes,
  output logic [SEC_W-1:0]  seconds,
  output logic              blank_hours,
  output logic              blank_minutes,
  output logic              setting,
  output logic              day_pulse
);

  localparam int TO_W = $clog2(TIMEOUT_S + 1);

  ctrl_state_t     state;
  ctrl_state_t     next_state;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_cnt_next;

  logic any_btn;
  logic edit_inc;
  logic edit_dec;
  logic run_tick;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;
  logic sec_clr;
  logic min_inc;
  logic min_dec;
  logic hour_inc;
  logic hour_dec;

  assign any_btn  = btn_mode || btn_inc || btn_dec;
  assign edit_inc = btn_inc && !btn_dec && !btn_mode;
  assign edit_dec = btn_dec && !btn_inc && !btn_mode;
  assign run_tick = (state == ST_RUN) && tick_1hz;

  always_comb begin
    next_state  = state;
    to_cnt_next = to_cnt;
    case (state)
      ST_RUN: begin
        to_cnt_next = '0;
        if (btn_mode) next_state = ST_SET_HOUR;
      end
      ST_SET_HOUR, ST_SET_MIN: begin
        if (any_btn)       to_cnt_next = '0;
        else if (tick_1hz) to_cnt_next = to_cnt + 1'b1;
        if (btn_mode)
          next_state = (state == ST_SET_HOUR) ? ST_SET_MIN : ST_RUN;
        else if (to_cnt_next == TO_W'(TIMEOUT_S))
          next_state = ST_RUN;
      end
      default: next_state = ST_RUN;
    endcase
    if (next_state == ST_RUN) to_cnt_next = '0;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_RUN;
      to_cnt <= '0;
    end else begin
      state  <= next_state;
      to_cnt <= to_cnt_next;
    end
  end

  // Carries only ripple in RUN; edits in a set state never cross fields.
  assign sec_clr  = (state == ST_SET_MIN) && (next_state == ST_RUN);
  assign min_inc  = (state == ST_RUN) ? sec_wrap : ((state == ST_SET_MIN) && edit_inc);
  assign min_dec  = (state == ST_SET_MIN) && edit_dec;
  assign hour_inc = (state == ST_RUN) ? min_wrap : ((state == ST_SET_HOUR) && edit_inc);
  assign hour_dec = (state == ST_SET_HOUR) && edit_dec;

  mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
    .clk   (clk),
    .rst_n (rst_i),
    .inc   (run_tick),
    .dec   (1'b0),
    .clr   (sec_clr),
    .value (seconds),
    .wrap  (sec_wrap)
  );

  mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
    .clk   (clk),
    .rst_n (rst_i),
    .inc   (min_inc),
    .dec   (min_dec),
    .clr   (1'b0),
    .value (minutes),
    .wrap  (min_wrap)
  );

  mod_counter #(.MOD(HOURS_MOD), .W(HOUR_W)) u_hour (
    .clk   (clk),
    .rst_n (rst_i),
    .inc   (hour_inc),
    .dec   (hour_dec),
    .clr   (1'b0),
    .value (hours),
    .wrap  (hour_wrap)
  );

  // Status flags are registered from next_state so they align with the fields.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      blank_hours   <= 1'b0;
      blank_minutes <= 1'b0;
      setting       <= 1'b0;
      day_pulse     <= 1'b0;
    end else begin
      blank_hours   <= (next_state == ST_SET_HOUR) && !blink;
      blank_minutes <= (next_state == ST_SET_MIN) && !blink;
      setting       <= (next_state != ST_RUN);
      day_pulse     <= run_tick && hour_wrap;
    end
  end

endmodule
`default_nettype wire
